// File: rtl/nyq_pkg.sv
// Shared types and constants for the NYQ frame packer.
package nyq_pkg;

    localparam int unsigned NYQ_PHASES = 8;
    localparam int unsigned NYQ_CNT_W  = 3;

    typedef logic [NYQ_CNT_W-1:0] nyq_phase_t;

    // A frame starts at phase 7 and finishes at phase 0.
    localparam nyq_phase_t NYQ_PHASE_FIRST = 3'd7;
    localparam nyq_phase_t NYQ_PHASE_LAST  = 3'd0;

    typedef enum logic {
        IDLE,
        RUN
    } nyq_pack_state_t;

    // Frame slot for a phase: phase 7 lands in slot 0 (frame LSBs).
    function automatic nyq_phase_t nyq_slot(input nyq_phase_t phase);
        return NYQ_PHASE_FIRST - phase;
    endfunction

endpackage

// File: rtl/nyq_frame_fifo.sv
// Synchronous FIFO for completed frames; push and pop together on a full
// FIFO are legal because the pop frees the slot the push refills.
module nyq_frame_fifo
    import nyq_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Storage and pointer update; storage is cleared so the read port is 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nyq_frame_packer.sv
// Packs eight NYQ phase samples (7..0) into one frame, checks phase
// continuity and queues completed frames for a valid/ready sink.
module nyq_frame_packer
    import nyq_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                     Clk_CI,
    input  logic                     Rst_RI,
    input  logic [NYQ_CNT_W-1:0]     Cnt_In_DI,
    input  logic [DATA_W-1:0]        Samp_DI,
    input  logic                     Samp_Valid_SI,
    output logic [8*DATA_W-1:0]      Frame_DO,
    output logic                     Frame_Valid_SO,
    input  logic                     Frame_Ready_SI,
    output logic                     Sync_Err_SO,
    output logic                     Ovf_SO
);

    localparam int unsigned FRAME_W = NYQ_PHASES * DATA_W;

    nyq_pack_state_t state_q, state_d;
    nyq_phase_t      exp_q, exp_d;
    nyq_phase_t      slot;
    logic [FRAME_W-1:0] part_q, part_d;
    logic [FRAME_W-1:0] push_data_q;
    logic            push_q;
    logic            complete;
    logic            start;
    logic            store;
    logic            sync_err_q, sync_err_d;
    logic            ovf_q;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;

    assign pop            = !fifo_empty && Frame_Ready_SI;
    assign Frame_Valid_SO = !fifo_empty;
    assign Sync_Err_SO    = sync_err_q;
    assign Ovf_SO         = ovf_q;

    // Next-state, expected phase and partial-frame update for one sample.
    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        part_d     = part_q;
        complete   = 1'b0;
        sync_err_d = 1'b0;
        start      = 1'b0;
        store      = 1'b0;
        slot       = nyq_slot(Cnt_In_DI);

        if (Samp_Valid_SI) begin
            unique case (state_q)
                IDLE: begin
                    if (Cnt_In_DI == NYQ_PHASE_FIRST) begin
                        start = 1'b1;
                    end
                end
                RUN: begin
                    if (Cnt_In_DI == exp_q) begin
                        store    = 1'b1;
                        exp_d    = exp_q - 1'b1;
                        complete = (Cnt_In_DI == NYQ_PHASE_LAST);
                    end else begin
                        sync_err_d = 1'b1;
                        if (Cnt_In_DI == NYQ_PHASE_FIRST) begin
                            start = 1'b1;
                        end else begin
                            state_d = IDLE;
                            exp_d   = NYQ_PHASE_FIRST;
                            part_d  = '0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // A phase-7 sample always opens a fresh frame, discarding any partial one.
        if (start) begin
            part_d  = '0;
            store   = 1'b1;
            exp_d   = NYQ_PHASE_FIRST - 1'b1;
            state_d = RUN;
        end

        if (store) begin
            for (int unsigned i = 0; i < NYQ_PHASES; i++) begin
                if (slot == nyq_phase_t'(i)) begin
                    part_d[i*DATA_W +: DATA_W] = Samp_DI;
                end
            end
        end
    end

    // FSM, partial frame, staged push and status flags.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            state_q     <= IDLE;
            exp_q       <= NYQ_PHASE_FIRST;
            part_q      <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            sync_err_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            part_q      <= part_d;
            sync_err_q  <= sync_err_d;
            push_q      <= complete;
            if (complete) begin
                push_data_q <= part_d;
            end
            if (push_q && fifo_full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // The completed frame is staged one cycle, so it enters the FIFO at the
    // edge after the phase-0 sample and Frame_DO stays fully registered.
    nyq_frame_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (Clk_CI),
        .rst       (Rst_RI),
        .push      (push_q),
        .push_data (push_data_q),
        .pop       (pop),
        .pop_data  (Frame_DO),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
